// File: rtl/decode_stage_pkg.sv
// Shared VeSPA decode definitions: opcodes, IR field positions and decode FSM states.
package decode_stage_pkg;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_NOT = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6;
    localparam logic [4:0] OP_CMP = 5'd7;
    localparam logic [4:0] OP_BXX = 5'd8;
    localparam logic [4:0] OP_JMP = 5'd9;
    localparam logic [4:0] OP_LD  = 5'd10;
    localparam logic [4:0] OP_LDI = 5'd11;
    localparam logic [4:0] OP_LDX = 5'd12;
    localparam logic [4:0] OP_ST  = 5'd13;
    localparam logic [4:0] OP_STX = 5'd14;
    localparam logic [4:0] OP_HLT = 5'd31;

    localparam int OPC_LSB    = 27;
    localparam int RDST_LSB   = 22;
    localparam int COND_LSB   = 23;
    localparam int RS1_LSB    = 17;
    localparam int IMMSEL_BIT = 16;
    localparam int RS2_LSB    = 11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, no reset.
module decode_stage_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2
);

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = mem_q[i_raddr1];
    assign o_rdata2 = mem_q[i_raddr2];

endmodule

// File: rtl/decode_stage.sv
// VeSPA decode stage: field split, operand read, immediate extension, output register and HLT FSM.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int PC_W = 32
) (
    input  logic            i_clk_d,
    input  logic            i_rst_d,
    input  logic [PC_W-1:0] i_PC_d,
    input  logic [31:0]     i_IR_d,
    input  logic            i_valid_d,
    input  logic            i_stall_d,
    input  logic            i_flush_d,
    input  logic            i_wb_en_d,
    input  logic [4:0]      i_wb_addr_d,
    input  logic [DW-1:0]   i_wb_data_d,
    output logic [PC_W-1:0] o_PC_d,
    output logic [4:0]      o_opcode_d,
    output logic [4:0]      o_rdst_d,
    output logic [3:0]      o_cond_d,
    output logic [DW-1:0]   o_op1_d,
    output logic [DW-1:0]   o_op2_d,
    output logic [DW-1:0]   o_imm_d,
    output logic            o_valid_d,
    output logic            o_halt_d
);

    function automatic logic [DW-1:0] sext16(input logic signed [15:0] v);
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] sext17(input logic signed [16:0] v);
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] sext22(input logic signed [21:0] v);
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] sext23(input logic signed [22:0] v);
        return DW'(v);
    endfunction

    logic [4:0]    opcode, rdst, rs1, rs2;
    logic [3:0]    cond;
    logic [DW-1:0] rd1, rd2, op1_src, op2_reg, op2_dec, imm_dec;

    assign opcode = i_IR_d[OPC_LSB +: 5];
    assign rdst   = i_IR_d[RDST_LSB +: 5];
    assign cond   = i_IR_d[COND_LSB +: 4];
    assign rs1    = i_IR_d[RS1_LSB +: 5];
    assign rs2    = i_IR_d[RS2_LSB +: 5];

    decode_stage_regfile #(.DW(DW), .NREG(NREG), .AW(5)) u_regfile (
        .i_clk    (i_clk_d),
        .i_we     (i_wb_en_d),
        .i_waddr  (i_wb_addr_d),
        .i_wdata  (i_wb_data_d),
        .i_raddr1 (rs1),
        .i_raddr2 (rs2),
        .o_rdata1 (rd1),
        .o_rdata2 (rd2)
    );

`ifdef DECODE_WB_BYPASS_EN
    assign op1_src = (i_wb_en_d && (i_wb_addr_d == rs1)) ? i_wb_data_d : rd1;
    assign op2_reg = (i_wb_en_d && (i_wb_addr_d == rs2)) ? i_wb_data_d : rd2;
`else
    assign op1_src = rd1;
    assign op2_reg = rd2;
`endif

    always_comb begin
        op2_dec = i_IR_d[IMMSEL_BIT] ? sext16(i_IR_d[15:0]) : op2_reg;
        imm_dec = '0;
        case (opcode)
            OP_LD, OP_ST:   imm_dec = DW'(i_IR_d[21:0]);
            OP_LDI:         imm_dec = sext22(i_IR_d[21:0]);
            OP_LDX, OP_STX: imm_dec = sext17(i_IR_d[16:0]);
            OP_BXX:         imm_dec = sext23(i_IR_d[22:0]);
            OP_JMP:         imm_dec = sext16(i_IR_d[15:0]);
            default:        imm_dec = '0;
        endcase
    end

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [4:0]      opcode_q, opcode_d, rdst_q, rdst_d;
    logic [3:0]      cond_q, cond_d;
    logic [DW-1:0]   op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
    logic            valid_q, valid_d, halt_q, halt_d;

    // Priority below reset: halt > stall > flush > load.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        rdst_d   = rdst_q;
        cond_d   = cond_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        imm_d    = imm_q;
        valid_d  = valid_q;
        halt_d   = halt_q;
        if (state_q == ST_HALT) begin
            valid_d = 1'b0;
            halt_d  = 1'b1;
        end else if (!i_stall_d) begin
            if (i_flush_d || !i_valid_d) begin
                valid_d = 1'b0;
            end else begin
                pc_d     = i_PC_d;
                opcode_d = opcode;
                rdst_d   = rdst;
                cond_d   = cond;
                op1_d    = op1_src;
                op2_d    = op2_dec;
                imm_d    = imm_dec;
                valid_d  = 1'b1;
                if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                    halt_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk_d) begin
        if (i_rst_d) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            opcode_q <= '0;
            rdst_q   <= '0;
            cond_q   <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            imm_q    <= '0;
            valid_q  <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            rdst_q   <= rdst_d;
            cond_q   <= cond_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            imm_q    <= imm_d;
            valid_q  <= valid_d;
            halt_q   <= halt_d;
        end
    end

    assign o_PC_d     = pc_q;
    assign o_opcode_d = opcode_q;
    assign o_rdst_d   = rdst_q;
    assign o_cond_d   = cond_q;
    assign o_op1_d    = op1_q;
    assign o_op2_d    = op2_q;
    assign o_imm_d    = imm_q;
    assign o_valid_d  = valid_q;
    assign o_halt_d   = halt_q;

endmodule
